// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time byte loader for the instruction memory
// Packs a big-endian byte stream into 32-bit words, writes them, then releases the CPU.
module imem_boot_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              boot_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  typedef enum logic [1:0] {LOAD, WRITE, RUN} state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t      state, state_nx;
  logic [1:0]  bcnt;
  logic [31:0] wbuf, word_nx;
  logic        fin;
  logic        accept, word_end, full;

  assign accept    = ld_valid && (state == LOAD);
  assign word_end  = accept && ((bcnt == 2'd3) || ld_last);
  assign full      = (word_count == FULL);
  assign ld_ready  = rst_n && (state == LOAD);
  assign cpu_stall = !boot_done;
  assign mem_raddr = cpu_addr;

  // Byte 0 lands in the MSB lane; lanes not yet filled stay zero for padding.
  always_comb begin
    word_nx = wbuf;
    case (bcnt)
      2'd0:    word_nx[31:24] = ld_data;
      2'd1:    word_nx[23:16] = ld_data;
      2'd2:    word_nx[15:8]  = ld_data;
      default: word_nx[7:0]   = ld_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (word_end) state_nx = WRITE;
      WRITE:   state_nx = fin ? RUN : LOAD;
      RUN:     if (reload) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt         <= 2'd0;
      wbuf         <= 32'd0;
      fin          <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 32'd0;
      boot_done    <= 1'b0;
      word_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            wbuf <= word_nx;
            bcnt <= bcnt + 2'd1;
            if (word_end) begin
              mem_wdata <= word_nx;
              mem_waddr <= word_count[ADDR_W-1:0];
              mem_we    <= !full;
              fin       <= ld_last;
              if (full) err_overflow <= 1'b1;
            end
          end
        end
        WRITE: begin
          bcnt <= 2'd0;
          wbuf <= 32'd0;
          // Saturates at full depth so an oversize image reports exactly 2^ADDR_W.
          if (!full) word_count <= word_count + (ADDR_W+1)'(1);
          if (fin) begin
            boot_done <= 1'b1;
            fin       <= 1'b0;
          end
        end
        RUN: begin
          if (reload) begin
            word_count   <= '0;
            bcnt         <= 2'd0;
            err_overflow <= 1'b0;
            boot_done    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
